// File: rtl/mux_stream_deserializer_if.sv
// Serial-in / word-out bundle between the mux stream producer, the deserializer and the word consumer.
// master drives the serial stream and the acknowledge; slave is the deserializer.
interface mux_stream_deserializer_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 3
);
   logic             din;
   logic             din_valid;
   logic             sync;
   logic             dout_ack;
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   logic             busy;
   logic [CNT_W-1:0] bit_cnt;
   logic             overrun;
   logic             frame_err;

   modport master (
      output din, din_valid, sync, dout_ack,
      input  dout, dout_valid, busy, bit_cnt, overrun, frame_err
   );

   modport slave (
      input  din, din_valid, sync, dout_ack,
      output dout, dout_valid, busy, bit_cnt, overrun, frame_err
   );
endinterface

// File: rtl/mux_stream_deserializer.sv
// Collects a sync-framed, bit-valid-qualified serial stream into WIDTH-bit words.
// Words are handed off with valid/ack; overrun is sticky and frame_err pulses on a broken frame.
module mux_stream_deserializer #(
   parameter int WIDTH     = 8,
   parameter int CNT_W     = 3,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst,
   mux_stream_deserializer_if.slave    bus
);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state;
   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] sr_next;
   logic [WIDTH-1:0] sr_first;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] dout_q;
   logic             dout_valid_q;
   logic             busy_q;
   logic             overrun_q;
   logic             frame_err_q;
   logic             last_bit;

   // sr_first is bit 0 of a fresh word, so stale partial bits never leak into it
   assign sr_next  = MSB_FIRST ? {sr[WIDTH-2:0], bus.din} : {bus.din, sr[WIDTH-1:1]};
   assign sr_first = MSB_FIRST ? {{(WIDTH-1){1'b0}}, bus.din} : {bus.din, {(WIDTH-1){1'b0}}};
   assign last_bit = (cnt == CNT_W'(WIDTH - 1));

   // NOTE: every register below uses <= so all of them see pre-edge values of each other.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         sr           <= '0;
         cnt          <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         overrun_q    <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         frame_err_q <= 1'b0;
         // consumption first; a completing word below may re-assert valid in the same cycle
         if (dout_valid_q && bus.dout_ack) dout_valid_q <= 1'b0;

         if (bus.sync) begin
            if (state == SHIFT && cnt != '0) frame_err_q <= 1'b1;
            state  <= SHIFT;
            busy_q <= 1'b1;
            if (bus.din_valid) begin
               sr  <= sr_first;
               cnt <= CNT_W'(1);
            end else begin
               sr  <= '0;
               cnt <= '0;
            end
         end else if (state == SHIFT && bus.din_valid) begin
            sr <= sr_next;
            if (last_bit) begin
               cnt <= '0;
               if (!dout_valid_q || bus.dout_ack) begin
                  dout_q       <= sr_next;
                  dout_valid_q <= 1'b1;
               end else begin
                  overrun_q <= 1'b1;
               end
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

   assign bus.dout       = dout_q;
   assign bus.dout_valid = dout_valid_q;
   assign bus.busy       = busy_q;
   assign bus.bit_cnt    = cnt;
   assign bus.overrun    = overrun_q;
   assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_mux_stream_deserializer.sv
// Directed bench: an MSB-first and an LSB-first deserializer share the same stimulus,
// checked against hand-computed expected words and status flags.
module tb_mux_stream_deserializer;
   localparam int WIDTH = 8;
   localparam int CNT_W = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   mux_stream_deserializer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) if_m ();
   mux_stream_deserializer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) if_l ();

   mux_stream_deserializer #(.WIDTH(WIDTH), .CNT_W(CNT_W), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .rst(rst), .bus(if_m.slave)
   );
   mux_stream_deserializer #(.WIDTH(WIDTH), .CNT_W(CNT_W), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .rst(rst), .bus(if_l.slave)
   );

   typedef struct {
      logic       sync;
      logic       dv;
      logic       din;
      logic       ack;
      logic       exp_valid;
      logic [7:0] exp_dout;
      int         exp_cnt;
      logic       exp_busy;
      logic       exp_ferr;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic s, input logic dv, input logic d, input logic a);
      if_m.sync = s;  if_m.din_valid = dv;  if_m.din = d;  if_m.dout_ack = a;
      if_l.sync = s;  if_l.din_valid = dv;  if_l.din = d;  if_l.dout_ack = a;
   endtask

   // inputs change 1 time unit after the rising edge; outputs are read at the same point
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic send_bits(input logic [7:0] bits, input bit with_sync, input logic ack_last);
      for (int i = 7; i >= 0; i--) begin
         drive((with_sync && i == 7), 1'b1, bits[i], (i == 0) ? ack_last : 1'b0);
         tick();
      end
      drive(0, 0, 0, 0);
   endtask

   vec_t vecs[10];
   logic [7:0] pat;

   initial begin
      // test 1: bits 1,0,1,1,0,0,1,0 -> B2 MSB-first, 4D LSB-first
      vecs[0] = '{1, 1, 1, 0, 0, 8'h00, 1, 1, 0};
      vecs[1] = '{0, 1, 0, 0, 0, 8'h00, 2, 1, 0};
      vecs[2] = '{0, 1, 1, 0, 0, 8'h00, 3, 1, 0};
      vecs[3] = '{0, 1, 1, 0, 0, 8'h00, 4, 1, 0};
      vecs[4] = '{0, 1, 0, 0, 0, 8'h00, 5, 1, 0};
      vecs[5] = '{0, 1, 0, 0, 0, 8'h00, 6, 1, 0};
      vecs[6] = '{0, 1, 1, 0, 0, 8'h00, 7, 1, 0};
      vecs[7] = '{0, 1, 0, 0, 1, 8'hB2, 0, 1, 0};
      vecs[8] = '{0, 0, 0, 1, 0, 8'hB2, 0, 1, 0};
      vecs[9] = '{0, 0, 1, 1, 0, 8'hB2, 0, 1, 0};

      do_reset();
      check("reset_dout",      if_m.dout,       0);
      check("reset_valid",     if_m.dout_valid, 0);
      check("reset_busy",      if_m.busy,       0);
      check("reset_cnt",       if_m.bit_cnt,    0);
      check("reset_overrun",   if_m.overrun,    0);
      check("reset_frame_err", if_m.frame_err,  0);

      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].sync, vecs[i].dv, vecs[i].din, vecs[i].ack);
         tick();
         check($sformatf("t1_valid[%0d]", i), if_m.dout_valid, vecs[i].exp_valid);
         check($sformatf("t1_dout[%0d]", i),  if_m.dout,       vecs[i].exp_dout);
         check($sformatf("t1_cnt[%0d]", i),   if_m.bit_cnt,    vecs[i].exp_cnt);
         check($sformatf("t1_busy[%0d]", i),  if_m.busy,       vecs[i].exp_busy);
         check($sformatf("t1_ferr[%0d]", i),  if_m.frame_err,  vecs[i].exp_ferr);
      end
      check("t1_lsb_dout", if_l.dout, 8'h4D);

      // test 2: same bits with random gaps; bit_cnt must hold during gaps
      do_reset();
      pat = 8'hB2;
      for (int i = 7; i >= 0; i--) begin
         drive((i == 7), 1'b1, pat[i], 1'b0);
         tick();
         for (int g = $urandom_range(0, 3); g > 0; g--) begin
            drive(0, 0, 1'($urandom), 0);
            tick();
            check("t2_gap_cnt", if_l.bit_cnt, (8 - i) % 8);
         end
      end
      drive(0, 0, 0, 0);
      check("t2_lsb_dout",  if_l.dout,       8'h4D);
      check("t2_lsb_valid", if_l.dout_valid, 1);
      check("t2_msb_dout",  if_m.dout,       8'hB2);

      // test 3: back-to-back words without ack -> second word dropped, overrun sticky
      do_reset();
      send_bits(8'hB2, 1, 0);
      check("t3_overrun_first", if_m.overrun, 0);
      send_bits(8'h5A, 0, 0);
      check("t3_dout",    if_m.dout,       8'hB2);
      check("t3_valid",   if_m.dout_valid, 1);
      check("t3_overrun", if_m.overrun,    1);
      tick();
      check("t3_overrun_sticky", if_m.overrun, 1);
      do_reset();
      check("t3_overrun_rst", if_m.overrun,    0);
      check("t3_valid_rst",   if_m.dout_valid, 0);

      // test 4: ack in the completion cycle of the second word
      do_reset();
      send_bits(8'hB2, 1, 0);
      for (int i = 7; i >= 0; i--) begin
         drive(0, 1'b1, pat[i] ^ 1'b0, 1'b0);
         pat = 8'h5A;
         drive(0, 1'b1, pat[i], (i == 0));
         tick();
         check("t4_valid_held", if_m.dout_valid, 1);
      end
      drive(0, 0, 0, 0);
      check("t4_dout",    if_m.dout,    8'h5A);
      check("t4_overrun", if_m.overrun, 0);
      tick();
      check("t4_valid_after", if_m.dout_valid, 1);

      // test 5: resync after 5 bits, then a clean word
      do_reset();
      drive(1, 1, 1, 0); tick();
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, 1, 0); tick();
      end
      check("t5_cnt_before", if_m.bit_cnt, 5);
      drive(1, 1, 1, 0); tick();
      check("t5_ferr",  if_m.frame_err,  1);
      check("t5_cnt",   if_m.bit_cnt,    1);
      check("t5_valid", if_m.dout_valid, 0);
      pat = 8'hB2;
      for (int i = 6; i >= 0; i--) begin
         drive(0, 1, pat[i], 0); tick();
         if (i == 6) check("t5_ferr_pulse", if_m.frame_err, 0);
      end
      drive(0, 0, 0, 0);
      check("t5_dout",       if_m.dout,       8'hB2);
      check("t5_valid_word", if_m.dout_valid, 1);

      // sync landing on what would be the final bit: no word, frame_err
      drive(0, 0, 0, 1); tick();
      drive(1, 1, 0, 0); tick();
      for (int i = 0; i < 6; i++) begin
         drive(0, 1, 1, 0); tick();
      end
      check("t5b_cnt7", if_m.bit_cnt, 7);
      drive(1, 1, 1, 0); tick();
      check("t5b_ferr",  if_m.frame_err,  1);
      check("t5b_valid", if_m.dout_valid, 0);
      check("t5b_cnt",   if_m.bit_cnt,    1);

      // test 6: reset mid-word, then unsynced bits are ignored
      do_reset();
      drive(1, 1, 1, 0); tick();
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 0, 0); tick();
      end
      check("t6_cnt4", if_m.bit_cnt, 4);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6_busy",  if_m.busy,       0);
      check("t6_cnt",   if_m.bit_cnt,    0);
      check("t6_valid", if_m.dout_valid, 0);
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 1, 0); tick();
         check("t6_ignored_cnt",  if_m.bit_cnt, 0);
         check("t6_ignored_busy", if_m.busy,    0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
